// File: rtl/bram_port_arbiter.sv
`default_nettype none

// ============================================================================
//  Package     : bash_hash_params_pkg
//  Description : Shared sizing parameters for the hash block. It provides
//                the default BRAM word-address width used by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bash_hash_params_pkg;
    parameter int ADDRLEN = 10;
endpackage : bash_hash_params_pkg

// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Shares one BRAM port (port A) between two requesters.
//                - host : the AXI-slave side
//                - core : the hash engine
//                A three-state owner FSM (IDLE / HOST / CORE) grants the port
//                to one requester at a time. The owner keeps the port for up
//                to MAX_BURST accepted beats. It then hands the port to the
//                other requester if that requester is waiting. Each accepted
//                beat gets a one-cycle completion pulse on the next cycle.
//                On that pulse, a read returns its data.
//
//  Parameters  : ADDRLEN    - BRAM word address width
//                MAX_BURST  - maximum consecutive accepted beats per grant
//                             (legal range 1..255)
//
//  Ports       : s_axi_aclk          in   clock for all logic
//                s_axi_aresetn       in   asynchronous active-low reset
//                host_/core_valid    in   access pending
//                host_/core_ready    out  access accepted when valid&ready
//                host_/core_we       in   byte write enables (0 = read)
//                host_/core_addr     in   word address
//                host_/core_wdata    in   write data
//                host_/core_resp_valid out completion pulse, one cycle after
//                                         each accepted beat
//                host_/core_rdata    out  read data, 0 unless a read completes
//                bram_en_a           out  BRAM enable (an access is accepted)
//                bram_we_a           out  BRAM byte write enables
//                bram_addr_a         out  BRAM address
//                bram_wrdata_a       out  BRAM write data
//                bram_rddata_a       in   BRAM read data, one cycle after en
//
//  Build macro : BRAM_ARB_RR_EN
//                When defined, a simultaneous request seen in IDLE goes to the
//                requester that did not own the port last.
//                When undefined, such a request always goes to the host.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDRLEN   = bash_hash_params_pkg::ADDRLEN,
    parameter int MAX_BURST = 8
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,

    // Host (AXI side) requester
    input  logic               host_valid,
    output logic               host_ready,
    input  logic [3:0]         host_we,
    input  logic [ADDRLEN-1:0] host_addr,
    input  logic [31:0]        host_wdata,
    output logic               host_resp_valid,
    output logic [31:0]        host_rdata,

    // Core (hash engine) requester
    input  logic               core_valid,
    output logic               core_ready,
    input  logic [3:0]         core_we,
    input  logic [ADDRLEN-1:0] core_addr,
    input  logic [31:0]        core_wdata,
    output logic               core_resp_valid,
    output logic [31:0]        core_rdata,

    // BRAM port A
    output logic               bram_en_a,
    output logic [3:0]         bram_we_a,
    output logic [ADDRLEN-1:0] bram_addr_a,
    output logic [31:0]        bram_wrdata_a,
    input  logic [31:0]        bram_rddata_a
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The burst counter holds the number of beats accepted before the current
    // one. An accepted beat that finds the counter at MAX_BURST-1 is the beat
    // that brings the count to MAX_BURST, so it ends the grant.
    localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_CORE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_burst_cnt;
    logic       r_host_resp;    // host beat accepted last cycle
    logic       r_core_resp;    // core beat accepted last cycle
    logic       r_host_rd;      // that host beat was a read
    logic       r_core_rd;      // that core beat was a read
`ifdef BRAM_ARB_RR_EN
    logic       r_last_owner_host;  // 1: the most recent grant went to host
`endif

    // ------------------------------------------------------------------------
    // Ownership and beat acceptance
    // ------------------------------------------------------------------------
    logic w_host_own;
    logic w_core_own;
    logic w_host_acc;
    logic w_core_acc;
    logic w_burst_end;
    logic w_host_release;
    logic w_core_release;
    logic w_tie_to_core;

    assign w_host_own = (r_state == ST_HOST);
    assign w_core_own = (r_state == ST_CORE);

    // Ready depends only on state, so a requester can never take the port
    // in the same cycle it first asks. Ownership is earned at a clock edge.
    assign host_ready = w_host_own;
    assign core_ready = w_core_own;

    assign w_host_acc = w_host_own & host_valid;
    assign w_core_acc = w_core_own & core_valid;

    assign w_burst_end = (r_burst_cnt == C_BURST_LAST);

    // The owner gives up the port when it stops asking, or when its beat
    // in this cycle uses up the burst allowance.
    assign w_host_release = w_host_own & (~host_valid | (w_host_acc & w_burst_end));
    assign w_core_release = w_core_own & (~core_valid | (w_core_acc & w_burst_end));

`ifdef BRAM_ARB_RR_EN
    assign w_tie_to_core = r_last_owner_host;
`else
    assign w_tie_to_core = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // BRAM port drive
    // ------------------------------------------------------------------------
    // Enable and write enables appear only for a beat that is really being
    // accepted. The BRAM therefore never sees an access that no requester
    // will get a response for. Address and data follow the owner.
    always_comb begin
        bram_en_a     = 1'b0;
        bram_we_a     = 4'h0;
        bram_addr_a   = '0;
        bram_wrdata_a = 32'h0;
        if (w_host_own) begin
            bram_en_a     = host_valid;
            bram_we_a     = host_valid ? host_we : 4'h0;
            bram_addr_a   = host_addr;
            bram_wrdata_a = host_wdata;
        end else if (w_core_own) begin
            bram_en_a     = core_valid;
            bram_we_a     = core_valid ? core_we : 4'h0;
            bram_addr_a   = core_addr;
            bram_wrdata_a = core_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Responses
    // ------------------------------------------------------------------------
    // The BRAM returns data one cycle after enable, which is the same cycle
    // as the completion pulse. Read data is passed through only for reads,
    // so write completions and idle cycles show zero.
    assign host_resp_valid = r_host_resp;
    assign core_resp_valid = r_core_resp;
    assign host_rdata      = (r_host_resp & r_host_rd) ? bram_rddata_a : 32'h0;
    assign core_rdata      = (r_core_resp & r_core_rd) ? bram_rddata_a : 32'h0;

    // ------------------------------------------------------------------------
    // Owner FSM, burst counter and response tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 8'd0;
            r_host_resp <= 1'b0;
            r_core_resp <= 1'b0;
            r_host_rd   <= 1'b0;
            r_core_rd   <= 1'b0;
`ifdef BRAM_ARB_RR_EN
            r_last_owner_host <= 1'b1;
`endif
        end else begin
            r_host_resp <= w_host_acc;
            r_core_resp <= w_core_acc;
            r_host_rd   <= w_host_acc & (host_we == 4'h0);
            r_core_rd   <= w_core_acc & (core_we == 4'h0);

            case (r_state)
                ST_IDLE: begin
                    r_burst_cnt <= 8'd0;
                    if (host_valid && core_valid) begin
                        r_state <= w_tie_to_core ? ST_CORE : ST_HOST;
`ifdef BRAM_ARB_RR_EN
                        r_last_owner_host <= ~w_tie_to_core;
`endif
                    end else if (host_valid) begin
                        r_state <= ST_HOST;
`ifdef BRAM_ARB_RR_EN
                        r_last_owner_host <= 1'b1;
`endif
                    end else if (core_valid) begin
                        r_state <= ST_CORE;
`ifdef BRAM_ARB_RR_EN
                        r_last_owner_host <= 1'b0;
`endif
                    end
                end

                ST_HOST: begin
                    if (w_host_release) begin
                        // Every grant starts with a fresh count, including
                        // a re-grant to the same owner.
                        r_burst_cnt <= 8'd0;
                        if (core_valid) begin
                            r_state <= ST_CORE;
`ifdef BRAM_ARB_RR_EN
                            r_last_owner_host <= 1'b0;
`endif
                        end else if (host_valid) begin
                            r_state <= ST_HOST;
`ifdef BRAM_ARB_RR_EN
                            r_last_owner_host <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_host_acc) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end

                ST_CORE: begin
                    if (w_core_release) begin
                        r_burst_cnt <= 8'd0;
                        if (host_valid) begin
                            r_state <= ST_HOST;
`ifdef BRAM_ARB_RR_EN
                            r_last_owner_host <= 1'b1;
`endif
                        end else if (core_valid) begin
                            r_state <= ST_CORE;
`ifdef BRAM_ARB_RR_EN
                            r_last_owner_host <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_core_acc) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule : bram_port_arbiter

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none

// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Self-checking bench for bram_port_arbiter. It builds two
//                instances that share the same stimulus:
//                - u_dut0 with MAX_BURST=4, connected to a BRAM model
//                - u_dut1 with MAX_BURST=1, with its read data tied low
//                A vector table drives single-cycle behaviour. Hand-written
//                sequences cover bursts, alternation and reset mid-burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          host_valid, core_valid;
    logic [3:0]    host_we, core_we;
    logic [AW-1:0] host_addr, core_addr;
    logic [31:0]   host_wdata, core_wdata;

    logic          hr0, cr0, hresp0, cresp0, en0;
    logic [3:0]    we0;
    logic [AW-1:0] addr0;
    logic [31:0]   hrd0, crd0, wd0, rd0;

    logic          hr1, cr1, hresp1, cresp1, en1;
    logic [3:0]    we1;
    logic [AW-1:0] addr1;
    logic [31:0]   hrd1, crd1, wd1;

    bram_port_arbiter #(.ADDRLEN(AW), .MAX_BURST(4)) u_dut0 (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .host_valid(host_valid), .host_ready(hr0), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_resp_valid(hresp0), .host_rdata(hrd0),
        .core_valid(core_valid), .core_ready(cr0), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_resp_valid(cresp0), .core_rdata(crd0),
        .bram_en_a(en0), .bram_we_a(we0), .bram_addr_a(addr0),
        .bram_wrdata_a(wd0), .bram_rddata_a(rd0)
    );

    bram_port_arbiter #(.ADDRLEN(AW), .MAX_BURST(1)) u_dut1 (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .host_valid(host_valid), .host_ready(hr1), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_resp_valid(hresp1), .host_rdata(hrd1),
        .core_valid(core_valid), .core_ready(cr1), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_resp_valid(cresp1), .core_rdata(crd1),
        .bram_en_a(en1), .bram_we_a(we1), .bram_addr_a(addr1),
        .bram_wrdata_a(wd1), .bram_rddata_a(32'h0)
    );

    // BRAM model: read-first, one-cycle read latency, byte write enables.
    // It is preloaded while reset is low.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
            mem[16] <= 32'hDEADBEEF;
            mem[3]  <= 32'hCAFE0003;
            rd0     <= 32'h0;
        end else if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0[b]) mem[addr0][8*b +: 8] <= wd0[8*b +: 8];
            rd0 <= mem[addr0];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          hv, cv;
        logic [3:0]    hwe, cwe;
        logic [AW-1:0] haddr, caddr;
        logic [31:0]   hwd, cwd;
        logic          ehr, ecr, een;
        logic [3:0]    ewe;
        logic [AW-1:0] eaddr;
        logic          ehresp, ecresp;
        logic [31:0]   ehrd, ecrd;
    } vec_t;

    vec_t tv [13];

    function automatic vec_t mk(
        input logic hv, input logic [3:0] hwe, input logic [AW-1:0] haddr, input logic [31:0] hwd,
        input logic cv, input logic [3:0] cwe, input logic [AW-1:0] caddr, input logic [31:0] cwd,
        input logic ehr, input logic ecr, input logic een, input logic [3:0] ewe,
        input logic [AW-1:0] eaddr, input logic ehresp, input logic ecresp,
        input logic [31:0] ehrd, input logic [31:0] ecrd);
        vec_t v;
        v.hv = hv; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.cv = cv; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.ehr = ehr; v.ecr = ecr; v.een = een; v.ewe = ewe; v.eaddr = eaddr;
        v.ehresp = ehresp; v.ecresp = ecresp; v.ehrd = ehrd; v.ecrd = ecrd;
        return v;
    endfunction

    task automatic drive(input logic hv, input logic cv, input logic [AW-1:0] ha, input logic [AW-1:0] ca);
        host_valid = hv; core_valid = cv;
        host_we = 4'h0; core_we = 4'h0;
        host_addr = ha; core_addr = ca;
        host_wdata = 32'h0; core_wdata = 32'h0;
    endtask

    logic ph0, pc0, ph1, pc1, eh0, eh1;

    initial begin
        //           hv hwe  haddr  hwd   cv cwe  caddr  cwd            hr cr en we   addr  hrsp crsp hrd           crd
        tv[0]  = mk(1, 4'h0, 10'h10, 0,   0, 4'h0, 10'h0, 0,            0, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[1]  = mk(1, 4'h0, 10'h10, 0,   0, 4'h0, 10'h0, 0,            1, 0, 1, 4'h0, 10'h10, 0, 0, 32'h0,        32'h0);
        tv[2]  = mk(0, 4'h0, 10'h0,  0,   0, 4'h0, 10'h0, 0,            1, 0, 0, 4'h0, 10'h0,  1, 0, 32'hDEADBEEF, 32'h0);
        tv[3]  = mk(0, 4'h0, 10'h0,  0,   1, 4'hF, 10'h3, 32'h12345678, 0, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[4]  = mk(0, 4'h0, 10'h0,  0,   1, 4'hF, 10'h3, 32'h12345678, 0, 1, 1, 4'hF, 10'h3,  0, 0, 32'h0,        32'h0);
        tv[5]  = mk(1, 4'h0, 10'h3,  0,   0, 4'h0, 10'h0, 0,            0, 1, 0, 4'h0, 10'h0,  0, 1, 32'h0,        32'h0);
        tv[6]  = mk(1, 4'h0, 10'h3,  0,   0, 4'h0, 10'h0, 0,            1, 0, 1, 4'h0, 10'h3,  0, 0, 32'h0,        32'h0);
        tv[7]  = mk(0, 4'h0, 10'h0,  0,   0, 4'h0, 10'h0, 0,            1, 0, 0, 4'h0, 10'h0,  1, 0, 32'h12345678, 32'h0);
        tv[8]  = mk(1, 4'h0, 10'h20, 0,   1, 4'h0, 10'h21, 0,           0, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[9]  = mk(0, 4'h0, 10'h0,  0,   0, 4'h0, 10'h0, 0,            1, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[10] = mk(1, 4'h0, 10'h20, 0,   1, 4'h0, 10'h21, 0,           0, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[11] = mk(0, 4'h0, 10'h0,  0,   0, 4'h0, 10'h0, 0,            1, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);
        tv[12] = mk(0, 4'h0, 10'h0,  0,   0, 4'h0, 10'h0, 0,            0, 0, 0, 4'h0, 10'h0,  0, 0, 32'h0,        32'h0);

        // Reset state: nonzero requests must not leak through while reset is low.
        rst_n = 1'b0;
        host_valid = 1'b1; core_valid = 1'b1; host_we = 4'hF; core_we = 4'hF;
        host_addr = 10'h55; core_addr = 10'h66; host_wdata = 32'h1; core_wdata = 32'h2;
        #1;
        chk("reset_dut0", {hr0, cr0, en0, we0, addr0, wd0, hresp0, cresp0, hrd0, crd0}, 128'h0);
        chk("reset_dut1", {hr1, cr1, en1, we1, addr1, wd1, hresp1, cresp1, hrd1, crd1}, 128'h0);
        repeat (3) @(negedge clk);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors on u_dut0.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            host_valid = tv[i].hv; host_we = tv[i].hwe; host_addr = tv[i].haddr; host_wdata = tv[i].hwd;
            core_valid = tv[i].cv; core_we = tv[i].cwe; core_addr = tv[i].caddr; core_wdata = tv[i].cwd;
            #1;
            chk($sformatf("vec%0d", i),
                {hr0, cr0, en0, we0, addr0, hresp0, cresp0, hrd0, crd0},
                {tv[i].ehr, tv[i].ecr, tv[i].een, tv[i].ewe, tv[i].eaddr,
                 tv[i].ehresp, tv[i].ecresp, tv[i].ehrd, tv[i].ecrd});
        end

        // Continuous requests from both sides. u_dut0 must serve bursts of 4
        // with no gap; u_dut1 must alternate every beat.
        @(negedge clk);
        drive(1, 1, 10'h40, 10'h41);
        #1;
        chk("burst_idle", {hr0, cr0, en0, hr1, cr1, en1}, 128'h0);
        ph0 = 0; pc0 = 0; ph1 = 0; pc1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            eh0 = ((i / 4) % 2 == 0);
            eh1 = (i % 2 == 0);
            chk($sformatf("burst4_grant%0d", i), {hr0, cr0, en0}, {eh0, ~eh0, 1'b1});
            chk($sformatf("burst4_resp%0d", i), {hresp0, cresp0}, {ph0, pc0});
            chk($sformatf("alt1_grant%0d", i), {hr1, cr1, en1}, {eh1, ~eh1, 1'b1});
            chk($sformatf("alt1_resp%0d", i), {hresp1, cresp1}, {ph1, pc1});
            ph0 = eh0; pc0 = ~eh0; ph1 = eh1; pc1 = ~eh1;
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        chk("burst_drop", {en0, hresp0, cresp0, en1, hresp1, cresp1}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        #1;
        chk("burst_idle_after", {hr0, cr0, hresp0, cresp0, hr1, cr1}, 128'h0);

        // Reset asserted in the middle of a host burst, just after beat 2 is accepted.
        @(negedge clk);
        drive(1, 0, 10'h10, 10'h0);
        #1;
        chk("mid_idle", {hr0, en0}, 128'h0);
        @(negedge clk);
        #1;
        chk("mid_beat1", {hr0, en0, hresp0}, {1'b1, 1'b1, 1'b0});
        @(negedge clk);
        #1;
        chk("mid_beat2", {hr0, en0, hresp0, hrd0}, {1'b1, 1'b1, 1'b1, 32'hDEADBEEF});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_async", {hr0, cr0, en0, we0, addr0, hresp0, cresp0, hrd0, crd0}, 128'h0);
        @(negedge clk);
        #1;
        chk("mid_reset_hold", {hr0, en0, hresp0, cresp0, hrd0}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_idle", {hr0, en0, hresp0}, 128'h0);
        @(negedge clk);
        #1;
        chk("post_reset_grant", {hr0, en0, hresp0}, {1'b1, 1'b1, 1'b0});
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        chk("post_reset_resp", {hr0, en0, hresp0}, {1'b1, 1'b0, 1'b1});
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bram_port_arbiter

`default_nettype wire
